// File: rtl/seq_mult.sv
// seq_mult: shift-add sequential multiplier, one partial product per clock.
// Accepts a start in IDLE or DONE, spends WIDTH cycles in CALC (busy=1),
// then pulses done for one cycle in DONE with the product on out.
// Optional build macro: SEQ_MULT_SIGNED_EN selects two's-complement operands.
//
// Handshake: start is sampled on a rising edge only when the FSM is in IDLE
// or DONE (busy=0); a sampled start latches a/b. done is a one-cycle valid
// strobe for out, and out holds its value until the next done.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [2*WIDTH-1:0] mcand;    // multiplicand, pre-shifted by the current bit index
  logic [WIDTH-1:0]   mplier;   // multiplier, shifted right so bit 0 is the current bit
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nx;
  logic [2*WIDTH-1:0] a_ext;
  logic [CW-1:0]      cnt;
  logic               last_bit;

  assign dbg_state = state;
  assign last_bit  = (cnt == CW'(WIDTH - 1));

  // Extend the multiplicand to the full product width.
`ifdef SEQ_MULT_SIGNED_EN
  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
`else
  assign a_ext = {{WIDTH{1'b0}}, a};
`endif

  // Accumulate one partial product; the sign bit's weight is negative in signed mode.
  always_comb begin
    acc_nx = acc;
    if (mplier[0]) begin
`ifdef SEQ_MULT_SIGNED_EN
      if (last_bit) acc_nx = acc - mcand;
      else          acc_nx = acc + mcand;
`else
      acc_nx = acc + mcand;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        state_nx = start ? CALC : IDLE;
      end
      CALC: begin
        busy = 1'b1;
        if (last_bit) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? CALC : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift-add in CALC, publish on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
    end else begin
      case (state)
        CALC: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_bit) out <= acc_nx;
        end
        default: begin
          if (start) begin
            mcand  <= a_ext;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
      endcase
    end
  end

endmodule
